// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit.
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE,
    FAIL
  } lsu_state_t;

  localparam logic [1:0] BE_WORD = 2'b11;
  localparam logic [1:0] BE_LO   = 2'b01;
  localparam logic [1:0] BE_HI   = 2'b10;

endpackage

// File: rtl/lsu_load_align.sv
// Load data alignment: byte-lane select with zero/sign extension, or word passthrough.
module lsu_load_align #(
  parameter int unsigned DATA_W = 16
) (
  input  logic [DATA_W-1:0] rdata,
  input  logic              byte_mode,
  input  logic              lane_hi,
  input  logic              sign_ext,
  output logic [DATA_W-1:0] data
);

  logic [7:0] lane;
  logic       fill;

  always_comb begin
    lane = lane_hi ? rdata[15:8] : rdata[7:0];
    fill = sign_ext & lane[7];
    if (byte_mode) data = {{(DATA_W-8){fill}}, lane};
    else           data = rdata;
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store unit: one req/ack bus access per start, load result held on mem_in.
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              we,
  input  logic              byte_mode,
  input  logic              sign_ext,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [1:0]        mem_be,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] mem_in,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  lsu_state_t        state, state_nxt;
  logic [CW-1:0]     cnt;
  logic              req_we, req_byte, req_sext, req_lane;
  logic [DATA_W-1:0] load_data;

  lsu_load_align #(.DATA_W(DATA_W)) u_align (
    .rdata     (mem_rdata),
    .byte_mode (req_byte),
    .lane_hi   (req_lane),
    .sign_ext  (req_sext),
    .data      (load_data)
  );

  always_comb begin
    state_nxt = state;
    mem_req   = 1'b0;
    done      = 1'b0;
    err       = 1'b0;
    busy      = (state != IDLE);
    case (state)
      IDLE:   if (start) state_nxt = ACCESS;
      ACCESS: begin
        mem_req = 1'b1;
        // ack wins over a timeout landing on the same edge
        if (mem_ack)                      state_nxt = DONE;
        else if (cnt == CW'(TIMEOUT))     state_nxt = FAIL;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      FAIL: begin
        done      = 1'b1;
        err       = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    mem_we = mem_req & req_we;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      req_we    <= 1'b0;
      req_byte  <= 1'b0;
      req_sext  <= 1'b0;
      req_lane  <= 1'b0;
      mem_addr  <= '0;
      mem_be    <= '0;
      mem_wdata <= '0;
      mem_in    <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && start) begin
        cnt      <= '0;
        req_we   <= we;
        req_byte <= byte_mode;
        req_sext <= sign_ext;
        req_lane <= addr[0];
        if (byte_mode) begin
          mem_addr  <= addr;
          mem_be    <= addr[0] ? BE_HI : BE_LO;
          mem_wdata <= {(DATA_W/8){wdata[7:0]}};
        end else begin
          mem_addr  <= {addr[ADDR_W-1:1], 1'b0};
          mem_be    <= BE_WORD;
          mem_wdata <= wdata;
        end
      end
      if (state == ACCESS) begin
        if (mem_ack) begin
          if (!req_we) mem_in <= load_data;
        end else if (cnt != CW'(TIMEOUT)) begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Randomized bench for lsu_ctrl against a transaction-level reference model.
module tb_lsu_ctrl;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst, start, we, byte_mode, sign_ext, mem_ack;
  logic [15:0] addr, wdata, mem_rdata;
  logic        mem_req, mem_we, busy, done, err;
  logic [15:0] mem_addr, mem_wdata, mem_in;
  logic [1:0]  mem_be;

  int          checks   = 0;
  int          failures = 0;
  logic [15:0] exp_mem_in;

  always #5 clk = ~clk;

  lsu_ctrl #(.DATA_W(16), .ADDR_W(16), .TIMEOUT(TO)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .we        (we),
    .byte_mode (byte_mode),
    .sign_ext  (sign_ext),
    .addr      (addr),
    .wdata     (wdata),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_be    (mem_be),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .mem_in    (mem_in),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One access; t_waits > TO means the responder never acks.
  task automatic run_txn(input bit t_we, input bit t_bm, input bit t_se,
                         input logic [15:0] t_addr, input logic [15:0] t_wdata,
                         input logic [15:0] t_rdata, input int t_waits);
    logic [15:0] e_addr, e_wd, lane;
    logic [1:0]  e_be;
    int          n;
    bit          ok;
    ok     = (t_waits <= TO);
    e_addr = t_bm ? t_addr : (t_addr & 16'hFFFE);
    e_be   = !t_bm ? 2'b11 : (t_addr[0] ? 2'b10 : 2'b01);
    e_wd   = t_bm ? (t_wdata & 16'h00FF) * 16'd257 : t_wdata;

    @(negedge clk);
    check("idle_busy", busy, 0);
    start = 1'b1; we = t_we; byte_mode = t_bm; sign_ext = t_se;
    addr = t_addr; wdata = t_wdata; mem_ack = 1'b0;
    @(negedge clk);
    n = 0;
    while (mem_req === 1'b1 && n < 64) begin
      check("mem_addr", mem_addr, e_addr);
      check("mem_be", mem_be, e_be);
      check("mem_wdata", mem_wdata, e_wd);
      check("mem_we", mem_we, t_we);
      check("busy_acc", busy, 1);
      check("done_acc", done, 0);
      check("mem_in_acc", mem_in, exp_mem_in);
      start = 1'($urandom_range(0, 1));
      we = 1'($urandom); byte_mode = 1'($urandom); sign_ext = 1'($urandom);
      addr = 16'($urandom); wdata = 16'($urandom);
      if (n == t_waits) begin mem_ack = 1'b1; mem_rdata = t_rdata; end
      else begin mem_ack = 1'b0; mem_rdata = 16'($urandom); end
      n++;
      @(negedge clk);
    end
    check("req_cycles", n, ok ? t_waits + 1 : TO + 1);
    check("done", done, 1);
    check("err", err, !ok);
    if (ok && !t_we) begin
      if (!t_bm) lane = t_rdata;
      else       lane = t_addr[0] ? (t_rdata >> 8) : (t_rdata & 16'h00FF);
      if (t_bm && t_se && lane >= 16'd128) lane = lane + 16'hFF00;
      exp_mem_in = lane;
    end
    check("mem_in", mem_in, exp_mem_in);
    start = 1'($urandom_range(0, 1));
    mem_ack = 1'($urandom_range(0, 1));
    mem_rdata = 16'($urandom);
    @(negedge clk);
    start = 1'b0; mem_ack = 1'b0;
    check("done_clr", done, 0);
    check("busy_idle", busy, 0);
    check("mem_in_hold", mem_in, exp_mem_in);
  endtask

  initial begin
    int dones;
    rst = 1'b1; start = 1'b0; we = 1'b0; byte_mode = 1'b0; sign_ext = 1'b0;
    addr = '0; wdata = '0; mem_ack = 1'b0; mem_rdata = '0;
    exp_mem_in = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rst_req", mem_req, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_be", mem_be, 0);
    check("rst_wdata", mem_wdata, 0);
    check("rst_mem_in", mem_in, 0);

    run_txn(1'b0, 1'b0, 1'b0, 16'h0010, 16'h0000, 16'hBEEF, 0);
    check("word_load", mem_in, 16'hBEEF);
    run_txn(1'b1, 1'b1, 1'b0, 16'h0004, 16'h1234, 16'h0000, 0);
    check("store_keeps", mem_in, 16'hBEEF);
    run_txn(1'b0, 1'b1, 1'b1, 16'h0021, 16'h0000, 16'h80FF, 3);
    check("byte_sext", mem_in, 16'hFF80);
    run_txn(1'b0, 1'b1, 1'b0, 16'h0021, 16'h0000, 16'h80FF, 3);
    check("byte_zext", mem_in, 16'h0080);
    run_txn(1'b0, 1'b0, 1'b0, 16'h0030, 16'h0000, 16'h1111, TO + 1);
    check("timeout_hold", mem_in, 16'h0080);
    run_txn(1'b0, 1'b0, 1'b0, 16'h0032, 16'h0000, 16'h2222, TO);
    check("ack_at_limit", mem_in, 16'h2222);

    // start held high, ack held high: one access every three cycles
    @(negedge clk);
    start = 1'b1; we = 1'b0; byte_mode = 1'b0; addr = 16'h0100;
    mem_ack = 1'b1; mem_rdata = 16'h5A5A; dones = 0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      check("b2b_req", mem_req, (i % 3) == 1);
      check("b2b_busy", busy, (i % 3) != 0);
      if (done) dones++;
    end
    start = 1'b0; mem_ack = 1'b0;
    check("b2b_dones", dones, 4);
    exp_mem_in = 16'h5A5A;
    check("b2b_mem_in", mem_in, exp_mem_in);

    // reset in the middle of an access
    @(negedge clk);
    start = 1'b1; we = 1'b0; byte_mode = 1'b0; addr = 16'h0040;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_mem_in = '0;
    check("mid_rst_req", mem_req, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_mem_in", mem_in, 0);
    mem_ack = 1'b1; mem_rdata = 16'h1234;
    repeat (2) begin
      @(negedge clk);
      check("late_ack_busy", busy, 0);
      check("late_ack_mem_in", mem_in, 0);
    end
    mem_ack = 1'b0;
    run_txn(1'b0, 1'b0, 1'b0, 16'h0042, 16'h0000, 16'hC0DE, 1);
    check("post_rst_load", mem_in, 16'hC0DE);

    for (int k = 0; k < 40; k++) begin
      run_txn(1'($urandom), 1'($urandom), 1'($urandom), 16'($urandom),
              16'($urandom), 16'($urandom), int'($urandom_range(0, TO + 2)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lsu_ctrl.md
Name: lsu_ctrl

Overview:
- Load/store unit sitting directly upstream of the source mux.
- Executes one memory access per request over a req/ack data-memory bus, with word or byte size.
- Captures load data into a holding register that drives the mux's mem_in input.
- Raises busy so the control unit stalls until done, and flags accesses that time out.

Parameters:
- DATA_W, 16, data bus and mem_in width.
- ADDR_W, 16, byte address width.
- TIMEOUT, 255, max cycles in ACCESS without mem_ack before abort; counter width = $clog2(TIMEOUT+1).

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  request a new access; sampled only in IDLE
- we  input  1  1 = store, 0 = load
- byte_mode  input  1  1 = byte access, 0 = word access
- sign_ext  input  1  byte load only: 1 = sign-extend, 0 = zero-extend
- addr  input  ADDR_W  byte address
- wdata  input  DATA_W  store data (byte store uses wdata[7:0])
- mem_req  output  1  bus request, held high until ack or timeout
- mem_we  output  1  bus write strobe qualifier
- mem_addr  output  ADDR_W  bus address (word access: addr with bit 0 forced to 0)
- mem_be  output  2  byte enables
- mem_wdata  output  DATA_W  bus write data
- mem_ack  input  1  bus completion; valid only while mem_req high
- mem_rdata  input  DATA_W  bus read data, valid with mem_ack
- mem_in  output  DATA_W  last completed load result
- busy  output  1  high whenever state != IDLE
- done  output  1  one-cycle pulse on completion (normal or timeout)
- err  output  1  one-cycle pulse coincident with done on timeout

Behaviour:
- Reset values:
  - state = IDLE
  - mem_req, mem_we, done, err, busy = 0
  - mem_addr, mem_be, mem_wdata = 0
  - mem_in = 0
  - timeout counter = 0
- States and transitions:
  - IDLE -> ACCESS when start=1.
  - ACCESS -> DONE on mem_ack=1.
  - ACCESS -> FAIL when the counter reaches TIMEOUT with no ack.
  - DONE -> IDLE and FAIL -> IDLE unconditionally.
- Request latch: on the start edge in IDLE, latch we, byte_mode, sign_ext, addr and wdata. All bus outputs are registered and stay stable for the whole ACCESS state.
- Bus outputs:
  - mem_req = 1 in ACCESS only.
  - mem_be: word = 2'b11; byte = addr[0] ? 2'b10 : 2'b01.
  - mem_wdata: word = wdata; byte = {wdata[7:0], wdata[7:0]}.
- Timing:
  - start at edge N gives mem_req=1 from cycle N+1.
  - Ack sampled at cycle K (K >= N+1) gives done=1 in cycle K+1, then busy=0 in cycle K+2.
  - Minimum latency start-to-done is 2 cycles (zero-wait ack).
- Load capture, on the ack edge only:
  - Word load: mem_in = mem_rdata.
  - Byte load: lane = addr[0] ? mem_rdata[15:8] : mem_rdata[7:0], zero- or sign-extended to 16 bits per sign_ext.
- Stores never modify mem_in. mem_in holds its value until the next successful load.
- Timeout:
  - Counter clears on entry to ACCESS and increments each ACCESS cycle without ack.
  - When counter = TIMEOUT, go to FAIL: mem_req drops, mem_in is unchanged, and FAIL asserts done=1 and err=1 for one cycle.
  - Ack on the same edge the counter hits TIMEOUT counts as success (ack has priority).
- Ignored events:
  - start while busy is ignored; the request is not queued.
  - mem_ack outside ACCESS is ignored.
  - we/addr/wdata changes during ACCESS have no effect.
- Back-to-back: a start asserted in the DONE/FAIL cycle is ignored. The first accepted start is in the next IDLE cycle.
- Reset mid-operation: rst in any state clears to reset values at the next edge, including mem_in. A pending bus transaction is abandoned, and any ack after reset is ignored.

Decomposition:
- Shared package lsu_pkg:
  - state enum lsu_state_t {IDLE, ACCESS, DONE, FAIL}
  - be constants BE_WORD = 2'b11, BE_LO = 2'b01, BE_HI = 2'b10
- One natural sub-module, lsu_load_align: combinational lane select plus zero/sign extension of mem_rdata. It is reused later by the instruction fetch path.

Test Plan:
- Word load, zero-wait: start, we=0, addr=0x0010, ack in first ACCESS cycle with rdata=0xBEEF -> mem_req high 1 cycle, mem_be=2'b11, done 2 cycles after start, mem_in=0xBEEF, err=0.
- Byte load sign/zero: addr=0x0021, rdata=0x80FF, ack after 3 waits; sign_ext=1 -> mem_in=0xFF80, mem_be=2'b10; repeat with sign_ext=0 -> mem_in=0x0080.
- Byte store: addr=0x0004, wdata=0x1234 -> mem_we=1, mem_be=2'b01, mem_wdata=0x3434; mem_in keeps its prior value 0xBEEF.
- Timeout, TIMEOUT=4: no ack -> mem_req high exactly 5 cycles, then done=1 and err=1 same cycle, mem_in unchanged; ack on counter=TIMEOUT edge -> success, err=0.
- start held high continuously with ack each cycle -> accesses every 3 cycles (ACCESS, DONE, IDLE), no start accepted while busy=1.
- rst asserted mid-ACCESS -> next cycle mem_req=0, busy=0, mem_in=0x0000; later ack is ignored, and a new start completes normally.
